// File: rtl/mem_store_checker.sv
// -----------------------------------------------------------------------------
// mem_store_checker
//
// Store monitor that sits downstream of the multi-cycle MIPS core. It watches
// the data-memory write port and grades the program run:
//   - store of PASS_DATA to PASS_ADDR     -> PASS
//   - store of any data to ALLOW_ADDR     -> tolerated, keep running
//   - any other store                     -> FAIL (offending store captured)
//   - CYCLE_LIMIT run cycles, no verdict  -> TIMEOUT
// The three verdict states are terminal until reset.
//
// Every store seen while running is also pushed into a first-word-fall-through
// log so the run can be replayed afterwards by a bench or an FPGA debug path.
//
// Build option:
//   STORE_CHECKER_LOG_EN  defined   -> store log is built
//                         undefined -> no log storage; log_* outputs tied to 0
//                                      and log_rd is ignored
//
// Parameters:
//   PASS_ADDR    store address that, with PASS_DATA, ends the run as pass
//   PASS_DATA    data required at PASS_ADDR
//   ALLOW_ADDR   address whose stores are tolerated with any data
//   CYCLE_LIMIT  run cycles before timeout (>= 1)
//   DEPTH        store log entries (power of two, >= 2)
//
// Ports:
//   clk           in   single clock, rising edge
//   reset         in   synchronous, active-high
//   memwrite      in   CPU store strobe (one cycle per store)
//   dataadr       in   store byte address
//   writedata     in   store data
//   log_rd        in   pop the log head
//   done          out  verdict reached (state != RUN)
//   pass          out  state == PASS
//   fail          out  state == FAIL
//   timeout       out  state == TIMEOUT
//   bad_addr      out  address of the store that caused FAIL
//   bad_data      out  data of the store that caused FAIL
//   store_count   out  stores seen while running, saturating
//   log_valid     out  log not empty
//   log_addr      out  address field of the log head (0 when empty)
//   log_data      out  data field of the log head (0 when empty)
//   log_overflow  out  sticky: a store was dropped because the log was full
// -----------------------------------------------------------------------------
module mem_store_checker #(
  parameter logic [31:0] PASS_ADDR   = 32'd84,
  parameter logic [31:0] PASS_DATA   = 32'd7,
  parameter logic [31:0] ALLOW_ADDR  = 32'd80,
  parameter logic [31:0] CYCLE_LIMIT = 32'd1000,
  parameter int unsigned DEPTH       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic        log_rd,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] bad_addr,
  output logic [31:0] bad_data,
  output logic [15:0] store_count,
  output logic        log_valid,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] cycle_q;

  // A store only counts while the run is still open; verdict states ignore it.
  logic store_run;
  logic is_pass_store;
  logic is_allow_store;
  logic at_limit;

  assign store_run      = memwrite && (state_q == ST_RUN);
  assign is_pass_store  = (dataadr == PASS_ADDR) && (writedata == PASS_DATA);
  assign is_allow_store = (dataadr == ALLOW_ADDR);
  assign at_limit       = (cycle_q == CYCLE_LIMIT - 32'd1);

  // ---------------------------------------------------------------------------
  // Verdict FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Pass is checked before allow so that PASS_ADDR == ALLOW_ADDR still passes
  // on the right data. A verdict-causing store beats the timeout in the same
  // cycle; an allowed store is not a verdict, so the timeout still fires.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (memwrite && is_pass_store) begin
          state_d = ST_PASS;
        end else if (memwrite && !is_allow_store) begin
          state_d = ST_FAIL;
        end else if (at_limit) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: state_d = state_q;
    endcase
  end

  assign done    = (state_q != ST_RUN);
  assign pass    = (state_q == ST_PASS);
  assign fail    = (state_q == ST_FAIL);
  assign timeout = (state_q == ST_TIMEOUT);

  // ---------------------------------------------------------------------------
  // Run-cycle counter, store counter and failing-store capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q     <= '0;
      store_count <= '0;
      bad_addr    <= '0;
      bad_data    <= '0;
    end else begin
      if (state_q == ST_RUN) begin
        cycle_q <= cycle_q + 32'd1;
      end
      if (store_run && (store_count != 16'hFFFF)) begin
        store_count <= store_count + 16'd1;
      end
      // Capture only on the transition into FAIL; terminal states hold it.
      if ((state_q == ST_RUN) && (state_d == ST_FAIL)) begin
        bad_addr <= dataadr;
        bad_data <= writedata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Store log
  // ---------------------------------------------------------------------------
`ifdef STORE_CHECKER_LOG_EN
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [63:0]   log_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] log_cnt;
  logic          log_ovf_q;
  logic          log_empty;
  logic          log_full;
  logic          do_pop;
  logic          do_push;

  assign log_empty = (log_cnt == '0);
  assign log_full  = (log_cnt == CW'(DEPTH));
  // A pop on an empty log is ignored; a full log still accepts a push when
  // the head is leaving in the same cycle.
  assign do_pop    = log_rd && !log_empty;
  assign do_push   = store_run && (!log_full || do_pop);

  // NOTE: the storage array has no reset; the count alone says which entries
  // are live, so clearing the data would add logic for no behavioural gain.
  always_ff @(posedge clk) begin
    if (do_push) begin
      log_mem[wr_ptr] <= {dataadr, writedata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      log_cnt   <= '0;
      log_ovf_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   log_cnt <= log_cnt + CW'(1);
        2'b01:   log_cnt <= log_cnt - CW'(1);
        default: log_cnt <= log_cnt;
      endcase
      if (store_run && log_full && !do_pop) begin
        log_ovf_q <= 1'b1;
      end
    end
  end

  // Head is read combinationally so a freshly pushed entry is visible right
  // after its write edge (first-word fall-through, no bubble).
  assign log_valid    = !log_empty;
  assign log_addr     = log_empty ? 32'd0 : log_mem[rd_ptr][63:32];
  assign log_data     = log_empty ? 32'd0 : log_mem[rd_ptr][31:0];
  assign log_overflow = log_ovf_q;
`else
  logic unused_log_rd;
  assign unused_log_rd = log_rd;

  assign log_valid    = 1'b0;
  assign log_addr     = 32'd0;
  assign log_data     = 32'd0;
  assign log_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mem_store_checker.sv
// -----------------------------------------------------------------------------
// tb_mem_store_checker
//
// Self-checking bench for mem_store_checker, built with CYCLE_LIMIT=20 and
// DEPTH=4 so timeout and log-full corners are reached quickly. A behavioural
// model (verdict variable, counters and a queue for the log) is advanced once
// per cycle and every DUT output is compared against it on the falling edge.
// Directed scenarios add explicit constant expectations on top.
// -----------------------------------------------------------------------------
module tb_mem_store_checker;

`ifdef STORE_CHECKER_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  localparam int LIMIT = 20;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        log_rd;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [31:0] bad_addr;
  logic [31:0] bad_data;
  logic [15:0] store_count;
  logic        log_valid;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        log_overflow;

  mem_store_checker #(
    .PASS_ADDR   (32'd84),
    .PASS_DATA   (32'd7),
    .ALLOW_ADDR  (32'd80),
    .CYCLE_LIMIT (32'd20),
    .DEPTH       (4)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .dataadr      (dataadr),
    .writedata    (writedata),
    .log_rd       (log_rd),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .bad_addr     (bad_addr),
    .bad_data     (bad_data),
    .store_count  (store_count),
    .log_valid    (log_valid),
    .log_addr     (log_addr),
    .log_data     (log_data),
    .log_overflow (log_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef enum {M_RUN, M_PASS, M_FAIL, M_TIMEOUT} verdict_t;

  verdict_t    m_verdict;
  int          m_run_cycles;
  logic [15:0] m_stores;
  logic [31:0] m_bad_addr;
  logic [31:0] m_bad_data;
  logic [63:0] m_log[$];
  bit          m_ovf;

  task automatic model_step(input bit rst, input bit we, input logic [31:0] a,
                            input logic [31:0] d, input bit rd);
    bit verdict_store;
    bit pushing;
    bit popping;
    int size_before;
    if (rst) begin
      m_verdict    = M_RUN;
      m_run_cycles = 0;
      m_stores     = 16'd0;
      m_bad_addr   = 32'd0;
      m_bad_data   = 32'd0;
      m_log.delete();
      m_ovf        = 1'b0;
      return;
    end
    size_before = m_log.size();
    popping     = rd && (size_before > 0);
    pushing     = LOG_EN && we && (m_verdict == M_RUN);
    if (m_verdict == M_RUN) begin
      verdict_store = 1'b0;
      if (we) begin
        if (m_stores != 16'hFFFF) m_stores = m_stores + 16'd1;
        if (a == 32'd84 && d == 32'd7) begin
          m_verdict     = M_PASS;
          verdict_store = 1'b1;
        end else if (a != 32'd80) begin
          m_verdict     = M_FAIL;
          m_bad_addr    = a;
          m_bad_data    = d;
          verdict_store = 1'b1;
        end
      end
      m_run_cycles++;
      if (!verdict_store && m_run_cycles == LIMIT) m_verdict = M_TIMEOUT;
    end
    if (popping) void'(m_log.pop_front());
    if (pushing) begin
      if (size_before < DEPTH || popping) m_log.push_back({a, d});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    exp_addr = (m_log.size() > 0) ? m_log[0][63:32] : 32'd0;
    exp_data = (m_log.size() > 0) ? m_log[0][31:0]  : 32'd0;
    check("done",         64'(done),         64'(m_verdict != M_RUN));
    check("pass",         64'(pass),         64'(m_verdict == M_PASS));
    check("fail",         64'(fail),         64'(m_verdict == M_FAIL));
    check("timeout",      64'(timeout),      64'(m_verdict == M_TIMEOUT));
    check("bad_addr",     64'(bad_addr),     64'(m_bad_addr));
    check("bad_data",     64'(bad_data),     64'(m_bad_data));
    check("store_count",  64'(store_count),  64'(m_stores));
    check("log_valid",    64'(log_valid),    64'(m_log.size() > 0));
    check("log_addr",     64'(log_addr),     64'(exp_addr));
    check("log_data",     64'(log_data),     64'(exp_data));
    check("log_overflow", 64'(log_overflow), 64'(m_ovf));
  endtask

  // One clock cycle: drive at the falling edge, let the rising edge act,
  // compare at the next falling edge.
  task automatic cyc(input bit rst, input bit we, input logic [31:0] a,
                     input logic [31:0] d, input bit rd);
    reset     = rst;
    memwrite  = we;
    dataadr   = a;
    writedata = d;
    log_rd    = rd;
    model_step(rst, we, a, d, rd);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    memwrite  = 1'b0;
    dataadr   = 32'd0;
    writedata = 32'd0;
    log_rd    = 1'b0;
    @(negedge clk);

    // Allowed store then pass store; log replays both in order.
    do_reset();
    check("s1_reset_count", 64'(store_count), 64'd0);
    store(32'd80, 32'd3);
    check("s1_run_after_allow", 64'(done), 64'd0);
    store(32'd84, 32'd7);
    check("s1_pass", 64'(pass), 64'd1);
    check("s1_count", 64'(store_count), 64'd2);
    check("s1_head0_addr", 64'(log_addr), LOG_EN ? 64'd80 : 64'd0);
    check("s1_head0_data", 64'(log_data), LOG_EN ? 64'd3 : 64'd0);
    pop();
    check("s1_head1_addr", 64'(log_addr), LOG_EN ? 64'd84 : 64'd0);
    check("s1_head1_data", 64'(log_data), LOG_EN ? 64'd7 : 64'd0);
    pop();
    check("s1_log_empty", 64'(log_valid), 64'd0);
    pop();

    // Pass address with wrong data fails; later stores are ignored.
    do_reset();
    store(32'd84, 32'd5);
    check("s2_fail", 64'(fail), 64'd1);
    check("s2_bad_addr", 64'(bad_addr), 64'd84);
    check("s2_bad_data", 64'(bad_data), 64'd5);
    idle(1);
    store(32'd84, 32'd7);
    check("s2_still_fail", 64'(fail), 64'd1);
    check("s2_count_held", 64'(store_count), 64'd1);

    // Timeout after the 20th edge; a pass store on that edge wins instead.
    do_reset();
    idle(LIMIT - 1);
    check("s3_no_timeout_yet", 64'(timeout), 64'd0);
    idle(1);
    check("s3_timeout", 64'(timeout), 64'd1);
    do_reset();
    idle(LIMIT - 1);
    store(32'd84, 32'd7);
    check("s3_pass_over_timeout", 64'(pass), 64'd1);
    check("s3_not_timeout", 64'(timeout), 64'd0);

    // Log overflow with five stores into a depth-4 log.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      store(32'd80, 32'(i));
      idle(1);
    end
    check("s4_overflow", 64'(log_overflow), LOG_EN ? 64'd1 : 64'd0);
    for (int i = 1; i <= 4; i++) begin
      check("s4_pop_data", 64'(log_data), LOG_EN ? 64'(i) : 64'd0);
      pop();
    end
    check("s4_drained", 64'(log_valid), 64'd0);

    // Simultaneous push and pop while full: nothing dropped.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      store(32'd80, 32'(i));
      idle(1);
    end
    cyc(1'b0, 1'b1, 32'd80, 32'd5, 1'b1);
    check("s4b_no_overflow", 64'(log_overflow), 64'd0);
    for (int i = 2; i <= 5; i++) begin
      check("s4b_pop_data", 64'(log_data), LOG_EN ? 64'(i) : 64'd0);
      pop();
    end
    check("s4b_drained", 64'(log_valid), 64'd0);

    // Reset one cycle after a FAIL clears everything; the run can then pass.
    do_reset();
    store(32'd12, 32'd9);
    check("s5_fail", 64'(fail), 64'd1);
    idle(1);
    do_reset();
    check("s5_cleared_done", 64'(done), 64'd0);
    check("s5_cleared_bad", 64'(bad_addr), 64'd0);
    check("s5_cleared_count", 64'(store_count), 64'd0);
    store(32'd84, 32'd7);
    check("s5_pass", 64'(pass), 64'd1);

    // Randomised runs against the model, including mid-run resets and pops.
    for (int run = 0; run < 40; run++) begin
      bit prev_we;
      do_reset();
      prev_we = 1'b0;
      for (int c = 0; c < 32; c++) begin
        bit          rst;
        bit          we;
        bit          rd;
        logic [31:0] a;
        logic [31:0] d;
        rst = ($urandom_range(0, 59) == 0);
        we  = !prev_we && ($urandom_range(0, 2) == 0);
        rd  = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 4))
          0, 1, 2: a = 32'd80;
          3:       a = 32'd84;
          default: a = 32'($urandom_range(0, 31)) << 2;
        endcase
        d = ($urandom_range(0, 1) == 0) ? 32'd7 : 32'($urandom_range(0, 15));
        cyc(rst, we, a, d, rd);
        prev_we = we;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
